hood_mode_fsm: RTL

- Master mode controller for the range hood. It turns debounced single-cycle button pulses and a 1 Hz tick into the 3-bit hood state.
- The 3-bit state is the encoding that the status-flag decoder and the display logic consume.
- It owns the timed states: third-level (hurricane) run, delayed return to standby, and self-clean. For each it exposes the remaining seconds.
- It enforces the once-per-power-cycle hurricane rule.

---
 rtl/hood_mode_if.sv | 27 ++
 rtl/hood_mode_fsm.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hood_mode_if.sv
// Button/tick inputs and registered mode outputs between the hood controller and its surroundings.
// The master side drives the pulses; the slave side is the mode FSM.
interface hood_mode_if #(
  parameter int CNT_W = 8
);
  logic             tick_1hz;
  logic             power_btn;
  logic             mode_btn;
  logic             lvl1_btn;
  logic             lvl2_btn;
  logic             lvl3_btn;
  logic             clean_btn;
  logic [2:0]       state;
  logic [CNT_W-1:0] countdown;
  logic             third_used;
  logic             clean_done;

  modport master (
    output tick_1hz, power_btn, mode_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
    input  state, countdown, third_used, clean_done
  );

  modport slave (
    input  tick_1hz, power_btn, mode_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
    output state, countdown, third_used, clean_done
  );
endinterface

// File: rtl/hood_mode_fsm.sv
// Range hood master mode controller: button pulses and a 1 Hz tick drive the 3-bit hood state,
// the countdown of the timed states, and the once-per-power-cycle hurricane rule.
module hood_mode_fsm #(
  parameter int THIRD_SECS = 60,
  parameter int WAIT_SECS  = 60,
  parameter int CLEAN_SECS = 180,
  parameter int CNT_W      = 8
) (
  input logic        clk,
  input logic        rst_n,
  hood_mode_if.slave hood_io
);

  typedef enum logic [2:0] {
    OFF             = 3'b000,
    STANDBY         = 3'b001,
    MODE_SELECT     = 3'b010,
    FIRST_LEVEL     = 3'b011,
    SECOND_LEVEL    = 3'b100,
    THIRD_LEVEL     = 3'b101,
    SELF_CLEAN      = 3'b110,
    WAIT_TO_STANDBY = 3'b111
  } state_e;

  localparam logic [CNT_W-1:0] THIRD_LD = CNT_W'(THIRD_SECS);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_SECS);
  localparam logic [CNT_W-1:0] CLEAN_LD = CNT_W'(CLEAN_SECS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             third_q, third_d;
  logic             done_q, done_d;
  logic             expire;

  // A tick at countdown 1 (or an unexpected 0) ends the timed state instead of decrementing.
  assign expire = (cnt_q <= CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      third_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      third_q <= third_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    third_d = third_q;
    done_d  = 1'b0;

    if (hood_io.power_btn) begin
      state_d = (state_q == OFF) ? STANDBY : OFF;
      cnt_d   = '0;
      third_d = 1'b0;
    end else begin
      unique case (state_q)
        OFF: ;
        STANDBY: begin
          if (hood_io.mode_btn) begin
            state_d = MODE_SELECT;
          end else if (hood_io.clean_btn) begin
            state_d = SELF_CLEAN;
            cnt_d   = CLEAN_LD;
          end
        end
        MODE_SELECT: begin
          if (hood_io.mode_btn) begin
            state_d = STANDBY;
          end else if (hood_io.lvl1_btn) begin
            state_d = FIRST_LEVEL;
          end else if (hood_io.lvl2_btn) begin
            state_d = SECOND_LEVEL;
          end else if (hood_io.lvl3_btn && !third_q) begin
            state_d = THIRD_LEVEL;
            cnt_d   = THIRD_LD;
            third_d = 1'b1;
          end
        end
        FIRST_LEVEL, SECOND_LEVEL: begin
          if (hood_io.mode_btn) begin
            state_d = WAIT_TO_STANDBY;
            cnt_d   = WAIT_LD;
          end else if (hood_io.lvl1_btn) begin
            state_d = FIRST_LEVEL;
          end else if (hood_io.lvl2_btn) begin
            state_d = SECOND_LEVEL;
          end
        end
        THIRD_LEVEL: begin
          if (hood_io.mode_btn) begin
            state_d = WAIT_TO_STANDBY;
            cnt_d   = WAIT_LD;
          end else if (hood_io.tick_1hz) begin
            if (expire) state_d = SECOND_LEVEL;
            else        cnt_d   = cnt_q - CNT_ONE;
          end
        end
        WAIT_TO_STANDBY: begin
          if (hood_io.tick_1hz) begin
            if (expire) state_d = STANDBY;
            else        cnt_d   = cnt_q - CNT_ONE;
          end
        end
        SELF_CLEAN: begin
          if (hood_io.tick_1hz) begin
            if (expire) begin
              state_d = STANDBY;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: state_d = OFF;
      endcase
    end

    // Untimed states always show a zero countdown, which also covers every timeout exit.
    if (state_d != THIRD_LEVEL && state_d != WAIT_TO_STANDBY && state_d != SELF_CLEAN) begin
      cnt_d = '0;
    end
  end

  assign hood_io.state      = state_q;
  assign hood_io.countdown  = cnt_q;
  assign hood_io.third_used = third_q;
  assign hood_io.clean_done = done_q;

endmodule
